// File: rtl/mips_pkg.sv
// mips_pkg: shared decode types and constants for the MIPS R2000 decode stage.
package mips_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ  = 6'h04,
        OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
        OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F,
        OP_LW    = 6'h23, OP_SW   = 6'h2B
    } opcode_t;

    typedef enum logic [5:0] {
        FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03, FN_SLLV = 6'h04,
        FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR   = 6'h08, FN_SYSCALL = 6'h0C,
        FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23,
        FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27,
        FN_SLT  = 6'h2A, FN_SLTU = 6'h2B
    } funct_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLLV, ALU_SRLV, ALU_SRAV, ALU_LUI
    } alu_op_t;

    typedef struct packed {
        logic reg_we;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
        logic link;
    } ctrl_t;

    localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;
    localparam logic [4:0]  REG_RA     = 5'd31;
    localparam int          NREGS      = 32;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    // Unlisted R-type functs fall back to ADD; they are still legal R-type words.
    function automatic alu_op_t funct_alu(input logic [5:0] fn);
        case (fn)
            FN_SLL:          return ALU_SLL;
            FN_SRL:          return ALU_SRL;
            FN_SRA:          return ALU_SRA;
            FN_SLLV:         return ALU_SLLV;
            FN_SRLV:         return ALU_SRLV;
            FN_SRAV:         return ALU_SRAV;
            FN_SUB, FN_SUBU: return ALU_SUB;
            FN_AND:          return ALU_AND;
            FN_OR:           return ALU_OR;
            FN_XOR:          return ALU_XOR;
            FN_NOR:          return ALU_NOR;
            FN_SLT:          return ALU_SLT;
            FN_SLTU:         return ALU_SLTU;
            default:         return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// id_stage_if: IF/ID inputs, EX/WB feedback, IF control returns and ID/EX register outputs.
interface id_stage_if;
    import mips_pkg::*;

    logic [31:0] pc_in;
    logic [31:0] inst_in;
    logic        flush;
    logic        ex_reg_we;
    logic        ex_mem_read;
    logic [4:0]  ex_dest;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    logic        hold_pc;
    logic        hold_if;
    logic        br;
    logic [31:0] pc_branch;
    logic        except;

    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_rs_val;
    logic [31:0] id_rt_val;
    logic [31:0] id_imm;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    alu_op_t     id_alu_op;
    ctrl_t       id_ctrl;

    modport master (
        output pc_in, inst_in, flush, ex_reg_we, ex_mem_read, ex_dest, wb_we, wb_addr, wb_data,
        input  hold_pc, hold_if, br, pc_branch, except,
        input  id_valid, id_pc, id_rs_val, id_rt_val, id_imm, id_rs, id_rt, id_rd, id_alu_op, id_ctrl
    );

    modport slave (
        input  pc_in, inst_in, flush, ex_reg_we, ex_mem_read, ex_dest, wb_we, wb_addr, wb_data,
        output hold_pc, hold_if, br, pc_branch, except,
        output id_valid, id_pc, id_rs_val, id_rt_val, id_imm, id_rs, id_rt, id_rd, id_alu_op, id_ctrl
    );
endinterface

// File: rtl/id_regfile.sv
// id_regfile: 2-read/1-write register file, $0 hardwired to zero, synchronous clear.
// Build macro ID_RF_BYPASS_EN: a read of the register being written returns the write data.
module id_regfile
    import mips_pkg::*;
#(
    parameter int DEPTH = NREGS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    input  logic        we,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);
    logic [31:0] mem [DEPTH];

    // Storage: cleared on reset, writes to $0 are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '{default: '0};
        end else if (we && wr_addr != 5'd0) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Combinational read ports, optionally forwarding the same-cycle write
    always_comb begin
        rs_data = (rs_addr == 5'd0) ? 32'd0 : mem[rs_addr];
        rt_data = (rt_addr == 5'd0) ? 32'd0 : mem[rt_addr];
`ifdef ID_RF_BYPASS_EN
        if (we && wr_addr != 5'd0 && wr_addr == rs_addr) rs_data = wr_data;
        if (we && wr_addr != 5'd0 && wr_addr == rt_addr) rt_data = wr_data;
`else
        // Without forwarding the old value is presented; the WB->ID RAW case is left to stalling upstream.
`endif
    end
endmodule

// File: rtl/id_stage.sv
// id_stage: MIPS R2000 decode stage - decode, register read, hazard stalls,
// branch/jump resolution, illegal/SYSCALL detection and the ID/EX register.
// Build macro ID_RF_BYPASS_EN selects write-through register reads.
module id_stage
    import mips_pkg::*;
(
    input logic       clk,
    input logic       rst,
    id_stage_if.slave bus
);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_val, rt_val, sext_imm;

    assign op       = bus.inst_in[31:26];
    assign fn       = bus.inst_in[5:0];
    assign rs       = bus.inst_in[25:21];
    assign rt       = bus.inst_in[20:16];
    assign rd       = bus.inst_in[15:11];
    assign sext_imm = sext16(bus.inst_in[15:0]);

    id_regfile u_regfile (
        .clk     (clk),
        .rst     (rst),
        .rs_addr (rs),
        .rt_addr (rt),
        .rs_data (rs_val),
        .rt_data (rt_val),
        .we      (bus.wb_we),
        .wr_addr (bus.wb_addr),
        .wr_data (bus.wb_data)
    );

    logic        legal, is_syscall, is_jr, is_jump, is_cond, uses_rt;
    alu_op_t     alu_op;
    ctrl_t       ctrl;
    logic [4:0]  dest;
    logic [31:0] imm;

    // Field decode: control bundle, ALU op, destination register and immediate
    always_comb begin
        legal      = 1'b1;
        is_syscall = 1'b0;
        is_jr      = 1'b0;
        is_jump    = 1'b0;
        is_cond    = 1'b0;
        uses_rt    = 1'b0;
        alu_op     = ALU_ADD;
        ctrl       = '0;
        dest       = rt;
        imm        = sext_imm;
        case (op)
            OP_RTYPE: begin
                dest        = rd;
                uses_rt     = 1'b1;
                alu_op      = funct_alu(fn);
                is_jr       = (fn == FN_JR);
                is_syscall  = (fn == FN_SYSCALL);
                ctrl.reg_we = !(is_jr || is_syscall);
            end
            OP_ADDI, OP_ADDIU: begin ctrl.reg_we = 1'b1; ctrl.alu_src = 1'b1; end
            OP_SLTI: begin ctrl.reg_we = 1'b1; ctrl.alu_src = 1'b1; alu_op = ALU_SLT; end
            OP_ANDI: begin ctrl.reg_we = 1'b1; ctrl.alu_src = 1'b1; alu_op = ALU_AND; imm = {16'd0, bus.inst_in[15:0]}; end
            OP_ORI:  begin ctrl.reg_we = 1'b1; ctrl.alu_src = 1'b1; alu_op = ALU_OR;  imm = {16'd0, bus.inst_in[15:0]}; end
            OP_XORI: begin ctrl.reg_we = 1'b1; ctrl.alu_src = 1'b1; alu_op = ALU_XOR; imm = {16'd0, bus.inst_in[15:0]}; end
            OP_LUI:  begin ctrl.reg_we = 1'b1; ctrl.alu_src = 1'b1; alu_op = ALU_LUI; imm = {16'd0, bus.inst_in[15:0]}; end
            OP_LW: begin
                ctrl.reg_we     = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
            end
            OP_SW:  begin ctrl.mem_write = 1'b1; ctrl.alu_src = 1'b1; uses_rt = 1'b1; end
            OP_BEQ, OP_BNE: begin is_cond = 1'b1; uses_rt = 1'b1; alu_op = ALU_SUB; end
            OP_J:   is_jump = 1'b1;
            OP_JAL: begin
                is_jump     = 1'b1;
                ctrl.reg_we = 1'b1;
                ctrl.link   = 1'b1;
                dest        = REG_RA;
                imm         = bus.pc_in + 32'd8;
            end
            default: legal = 1'b0;
        endcase
        // Writes to $0 are architecturally void; this also makes the all-zero NOP write nothing.
        if (dest == 5'd0) ctrl.reg_we = 1'b0;
    end

    logic inst_valid, load_use, br_hazard, except_w, stall, taken, bubble;

    // Hazards, exception and branch resolution with flush > except > stall priority
    always_comb begin
        inst_valid = (bus.inst_in != 32'd0);
        load_use   = bus.ex_mem_read && bus.ex_dest != 5'd0 &&
                     (bus.ex_dest == rs || (uses_rt && bus.ex_dest == rt));
        br_hazard  = (is_cond || is_jr) && bus.ex_reg_we && bus.ex_dest != 5'd0 &&
                     (bus.ex_dest == rs || (is_cond && bus.ex_dest == rt));
        except_w   = inst_valid && !bus.flush && (!legal || is_syscall);
        stall      = inst_valid && !bus.flush && !except_w && (load_use || br_hazard);
        taken      = is_jump || is_jr ||
                     (op == OP_BEQ && rs_val == rt_val) || (op == OP_BNE && rs_val != rt_val);
        bubble     = bus.flush || except_w || stall || !inst_valid;

        bus.except  = except_w;
        bus.hold_pc = stall;
        bus.hold_if = stall;
        bus.br      = taken && !bubble;
        if (is_jump)    bus.pc_branch = {bus.pc_in[31:28], bus.inst_in[25:0], 2'b00};
        else if (is_jr) bus.pc_branch = rs_val;
        else            bus.pc_branch = bus.pc_in + 32'd4 + {sext_imm[29:0], 2'b00};
    end

    // ID/EX pipeline register; killed instructions leave an all-zero bubble
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            bus.id_valid  <= 1'b0;
            bus.id_pc     <= '0;
            bus.id_rs_val <= '0;
            bus.id_rt_val <= '0;
            bus.id_imm    <= '0;
            bus.id_rs     <= '0;
            bus.id_rt     <= '0;
            bus.id_rd     <= '0;
            bus.id_alu_op <= ALU_ADD;
            bus.id_ctrl   <= '0;
        end else begin
            bus.id_valid  <= 1'b1;
            bus.id_pc     <= bus.pc_in;
            bus.id_rs_val <= rs_val;
            bus.id_rt_val <= rt_val;
            bus.id_imm    <= imm;
            bus.id_rs     <= rs;
            bus.id_rt     <= rt;
            bus.id_rd     <= dest;
            bus.id_alu_op <= alu_op;
            bus.id_ctrl   <= ctrl;
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed scenarios plus randomized decode against a behavioural model.
module tb_id_stage;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    id_stage_if bus();
    id_stage dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    // Architectural register state as the bench understands it
    logic [31:0] rf [32];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (bus.wb_we && bus.wb_addr != 5'd0) begin
            rf[bus.wb_addr] <= bus.wb_data;
        end
    end

    typedef struct packed {
        logic        hold, br, exc, valid;
        logic [31:0] target, pc, a, b, imm;
        logic [4:0]  rs, rt, rd;
        alu_op_t     alu;
        logic [5:0]  ctrl;
    } exp_t;

    function automatic logic [31:0] rdreg(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef ID_RF_BYPASS_EN
        if (bus.wb_we && bus.wb_addr == a) return bus.wb_data;
`endif
        return rf[a];
    endfunction

    function automatic alu_op_t r_alu(input logic [5:0] f);
        alu_op_t r;
        r = ALU_ADD;
        if (f == 6'h00) r = ALU_SLL;  if (f == 6'h02) r = ALU_SRL;  if (f == 6'h03) r = ALU_SRA;
        if (f == 6'h04) r = ALU_SLLV; if (f == 6'h06) r = ALU_SRLV; if (f == 6'h07) r = ALU_SRAV;
        if (f == 6'h22 || f == 6'h23) r = ALU_SUB;
        if (f == 6'h24) r = ALU_AND;  if (f == 6'h25) r = ALU_OR;   if (f == 6'h26) r = ALU_XOR;
        if (f == 6'h27) r = ALU_NOR;  if (f == 6'h2A) r = ALU_SLT;  if (f == 6'h2B) r = ALU_SLTU;
        return r;
    endfunction

    function automatic exp_t model(input logic [31:0] pc, input logic [31:0] inst, input logic fl,
                                   input logic exwe, input logic exmr, input logic [4:0] exd);
        exp_t e;
        logic [5:0] op, fn;
        logic [4:0] s, t, d;
        logic legal, sys, jr, jump, cond, rt_used, we, mr, mw, src, lnk, live, lu, bh, taken;
        logic [31:0] se, a, b;
        op = inst[31:26]; fn = inst[5:0];
        s = inst[25:21]; t = inst[20:16]; d = inst[15:11];
        se = {{16{inst[15]}}, inst[15:0]};
        a = rdreg(s); b = rdreg(t);
        e = '0;
        e.alu = ALU_ADD; e.rd = t; e.imm = se;
        legal = 1; sys = 0; jr = 0; jump = 0; cond = 0; rt_used = 0;
        we = 0; mr = 0; mw = 0; src = 0; lnk = 0;
        case (op)
            6'h00: begin rt_used = 1; e.rd = d; e.alu = r_alu(fn); jr = (fn == 6'h08); sys = (fn == 6'h0C); we = !(jr || sys); end
            6'h02: jump = 1;
            6'h03: begin jump = 1; lnk = 1; we = 1; e.rd = 5'd31; e.imm = pc + 32'd8; end
            6'h04, 6'h05: begin cond = 1; rt_used = 1; e.alu = ALU_SUB; end
            6'h08, 6'h09: begin we = 1; src = 1; end
            6'h0A: begin we = 1; src = 1; e.alu = ALU_SLT; end
            6'h0C: begin we = 1; src = 1; e.alu = ALU_AND; e.imm = {16'd0, inst[15:0]}; end
            6'h0D: begin we = 1; src = 1; e.alu = ALU_OR;  e.imm = {16'd0, inst[15:0]}; end
            6'h0E: begin we = 1; src = 1; e.alu = ALU_XOR; e.imm = {16'd0, inst[15:0]}; end
            6'h0F: begin we = 1; src = 1; e.alu = ALU_LUI; e.imm = {16'd0, inst[15:0]}; end
            6'h23: begin we = 1; src = 1; mr = 1; end
            6'h2B: begin mw = 1; src = 1; rt_used = 1; end
            default: legal = 0;
        endcase
        if (e.rd == 5'd0) we = 0;
        live    = (inst != 32'd0) && !fl;
        e.exc   = live && (!legal || sys);
        lu      = exmr && exd != 0 && (exd == s || (rt_used && exd == t));
        bh      = (cond || jr) && exwe && exd != 0 && (exd == s || (cond && exd == t));
        e.hold  = live && !e.exc && (lu || bh);
        taken   = jump || jr || (op == 6'h04 && a == b) || (op == 6'h05 && a != b);
        e.valid = live && !e.exc && !e.hold;
        e.br    = taken && e.valid;
        e.target = jump ? {pc[31:28], inst[25:0], 2'b00} : (jr ? a : pc + 32'd4 + (se << 2));
        e.pc = pc; e.a = a; e.b = b; e.rs = s; e.rt = t;
        e.ctrl = {we, mr, mw, mr, src, lnk};
        return e;
    endfunction

    task automatic apply(input logic [31:0] pc, input logic [31:0] inst, input logic fl,
                         input logic exwe, input logic exmr, input logic [4:0] exd,
                         input logic wbwe, input logic [4:0] wba, input logic [31:0] wbd);
        @(negedge clk);
        bus.pc_in = pc; bus.inst_in = inst; bus.flush = fl;
        bus.ex_reg_we = exwe; bus.ex_mem_read = exmr; bus.ex_dest = exd;
        bus.wb_we = wbwe; bus.wb_addr = wba; bus.wb_data = wbd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        apply(32'h1234, 32'h2001_0005, 0, 0, 0, 0, 1, 5'd5, 32'hAAAA_AAAA);
        @(posedge clk); #1;
        checks++; if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.id_valid); end
        checks++; if ({bus.id_pc, bus.id_imm, 6'(bus.id_ctrl)} !== '0) begin failures++; $display("FAIL reset_regs pc=%h imm=%h ctrl=%b exp=0", bus.id_pc, bus.id_imm, bus.id_ctrl); end
        apply(32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        apply(32'h8, 32'h00A0_3020, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        checks++; if (bus.id_rs_val !== 32'd0) begin failures++; $display("FAIL reset_rf_cleared got=%h exp=0", bus.id_rs_val); end
    endtask

    task automatic test_addi();
        apply(32'h100, 32'h2001_0005, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if ({bus.hold_pc, bus.br, bus.except} !== 3'b000) begin failures++; $display("FAIL addi_comb got=%b exp=000", {bus.hold_pc, bus.br, bus.except}); end
        @(posedge clk); #1;
        checks++; if ({bus.id_valid, bus.id_rt, bus.id_rd, bus.id_imm} !== {1'b1, 5'd1, 5'd1, 32'd5}) begin failures++; $display("FAIL addi_fields got v=%b rt=%0d rd=%0d imm=%h exp v=1 rt=1 rd=1 imm=5", bus.id_valid, bus.id_rt, bus.id_rd, bus.id_imm); end
        checks++; if (bus.id_ctrl !== 6'b100010 || bus.id_pc !== 32'h100) begin failures++; $display("FAIL addi_ctrl got ctrl=%b pc=%h exp ctrl=100010 pc=100", bus.id_ctrl, bus.id_pc); end
    endtask

    task automatic test_load_use();
        apply(32'h200, 32'h0044_1820, 0, 0, 1, 5'd2, 0, 0, 0);
        #1;
        checks++; if ({bus.hold_pc, bus.hold_if} !== 2'b11) begin failures++; $display("FAIL lu_hold got=%b exp=11", {bus.hold_pc, bus.hold_if}); end
        @(posedge clk); #1;
        checks++; if (bus.id_valid !== 1'b0 || bus.id_ctrl !== 6'd0) begin failures++; $display("FAIL lu_bubble got v=%b ctrl=%b exp v=0 ctrl=0", bus.id_valid, bus.id_ctrl); end
        apply(32'h200, 32'h0044_1820, 0, 0, 0, 5'd2, 0, 0, 0);
        #1;
        checks++; if (bus.hold_pc !== 1'b0) begin failures++; $display("FAIL lu_release got=%b exp=0", bus.hold_pc); end
        @(posedge clk); #1;
        checks++; if ({bus.id_valid, bus.id_rd, 6'(bus.id_ctrl)} !== {1'b1, 5'd3, 6'b100000}) begin failures++; $display("FAIL lu_issue got v=%b rd=%0d ctrl=%b exp v=1 rd=3 ctrl=100000", bus.id_valid, bus.id_rd, bus.id_ctrl); end
        apply(32'h204, 32'h0044_1820, 0, 0, 1, 5'd4, 0, 0, 0);
        #1;
        checks++; if (bus.hold_if !== 1'b1) begin failures++; $display("FAIL lu_rt_match got=%b exp=1", bus.hold_if); end
        apply(32'h208, 32'h2024_0001, 0, 0, 1, 5'd4, 0, 0, 0);
        #1;
        checks++; if (bus.hold_if !== 1'b0) begin failures++; $display("FAIL lu_itype_rt_unused got=%b exp=0", bus.hold_if); end
    endtask

    task automatic test_branch();
        apply(32'h40, 32'h1021_0003, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (bus.br !== 1'b1 || bus.pc_branch !== 32'h50) begin failures++; $display("FAIL beq_taken got br=%b tgt=%h exp br=1 tgt=50", bus.br, bus.pc_branch); end
        apply(32'h40, 32'h1421_0003, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (bus.br !== 1'b0) begin failures++; $display("FAIL bne_not_taken got=%b exp=0", bus.br); end
        apply(32'h40, 32'h1000_FFFF, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (bus.br !== 1'b1 || bus.pc_branch !== 32'h40) begin failures++; $display("FAIL beq_back got br=%b tgt=%h exp br=1 tgt=40", bus.br, bus.pc_branch); end
        apply(32'h40, 32'h1021_0003, 0, 1, 0, 5'd1, 0, 0, 0);
        #1;
        checks++; if ({bus.hold_pc, bus.br} !== 2'b10) begin failures++; $display("FAIL br_stall got hold,br=%b exp=10", {bus.hold_pc, bus.br}); end
        apply(32'h40, 32'h1000_0003, 0, 1, 0, 5'd0, 0, 0, 0);
        #1;
        checks++; if ({bus.hold_pc, bus.br} !== 2'b01) begin failures++; $display("FAIL br_dest0 got hold,br=%b exp=01", {bus.hold_pc, bus.br}); end
    endtask

    task automatic test_jal();
        apply(32'h0, 32'h0C00_0100, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (bus.br !== 1'b1 || bus.pc_branch !== 32'h400) begin failures++; $display("FAIL jal_target got br=%b tgt=%h exp br=1 tgt=400", bus.br, bus.pc_branch); end
        @(posedge clk); #1;
        checks++; if ({bus.id_rd, bus.id_imm, 6'(bus.id_ctrl)} !== {5'd31, 32'h8, 6'b100001}) begin failures++; $display("FAIL jal_link got rd=%0d imm=%h ctrl=%b exp rd=31 imm=8 ctrl=100001", bus.id_rd, bus.id_imm, bus.id_ctrl); end
    endtask

    task automatic test_except_flush();
        apply(32'h60, 32'hFC40_0000, 0, 0, 1, 5'd2, 0, 0, 0);
        #1;
        checks++; if ({bus.except, bus.br, bus.hold_pc} !== 3'b100) begin failures++; $display("FAIL illegal got exc,br,hold=%b exp=100", {bus.except, bus.br, bus.hold_pc}); end
        @(posedge clk); #1;
        checks++; if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL illegal_bubble got=%b exp=0", bus.id_valid); end
        apply(32'h64, 32'h0000_000C, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (bus.except !== 1'b1) begin failures++; $display("FAIL syscall got=%b exp=1", bus.except); end
        apply(32'h68, 32'h0044_1820, 1, 0, 1, 5'd2, 0, 0, 0);
        #1;
        checks++; if (bus.hold_pc !== 1'b0) begin failures++; $display("FAIL flush_no_stall got=%b exp=0", bus.hold_pc); end
        @(posedge clk); #1;
        checks++; if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL flush_bubble got=%b exp=0", bus.id_valid); end
        apply(32'h6C, 32'h1000_0003, 1, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (bus.br !== 1'b0) begin failures++; $display("FAIL flush_br got=%b exp=0", bus.br); end
    endtask

    task automatic test_wb_bypass();
        logic [31:0] exp_same;
`ifdef ID_RF_BYPASS_EN
        exp_same = 32'hDEAD_BEEF;
`else
        exp_same = 32'h1111_2222;
`endif
        apply(32'h80, 32'h0, 0, 0, 0, 0, 1, 5'd5, 32'h1111_2222);
        apply(32'h84, 32'h00A0_3020, 0, 0, 0, 0, 1, 5'd5, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        checks++; if (bus.id_rs_val !== exp_same) begin failures++; $display("FAIL wb_same_cycle got=%h exp=%h", bus.id_rs_val, exp_same); end
        apply(32'h88, 32'h00A0_3020, 0, 0, 0, 0, 1, 5'd0, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        checks++; if (bus.id_rs_val !== 32'hDEAD_BEEF || bus.id_rt_val !== 32'd0) begin failures++; $display("FAIL wb_zero_reg got rs=%h rt=%h exp rs=deadbeef rt=0", bus.id_rs_val, bus.id_rt_val); end
        apply(32'h8C, 32'h00A0_0008, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (bus.br !== 1'b1 || bus.pc_branch !== 32'hDEAD_BEEF) begin failures++; $display("FAIL jr_target got br=%b tgt=%h exp br=1 tgt=deadbeef", bus.br, bus.pc_branch); end
    endtask

    logic [5:0] ops [16] = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
                             6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F};
    logic [5:0] fns [12] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h07, 6'h08, 6'h0C, 6'h20,
                             6'h22, 6'h25, 6'h27, 6'h2B};

    task automatic test_random();
        exp_t e;
        logic [31:0] pc, inst;
        logic [5:0]  op;
        logic [4:0]  s, t, d;
        logic        fl, exwe, exmr, wbwe;
        logic [4:0]  exd, wba;
        for (int n = 0; n < 600; n++) begin
            op = ops[$urandom_range(15)];
            s = 5'($urandom_range(7)); t = 5'($urandom_range(7)); d = 5'($urandom_range(7));
            if ((op == 6'h04 || op == 6'h05) && $urandom_range(1) == 1) t = s;
            if (op == 6'h00)                    inst = {op, s, t, d, 5'($urandom), fns[$urandom_range(11)]};
            else if (op == 6'h02 || op == 6'h03) inst = {op, 26'($urandom)};
            else                                inst = {op, s, t, 16'($urandom)};
            if ($urandom_range(9) == 0) inst = 32'd0;
            pc   = $urandom & 32'hFFFF_FFFC;
            fl   = ($urandom_range(15) == 0);
            exwe = 1'($urandom_range(1));
            exmr = ($urandom_range(3) == 0);
            exd  = 5'($urandom_range(7));
            wbwe = 1'($urandom_range(1));
            wba  = 5'($urandom_range(7));
            apply(pc, inst, fl, exwe, exmr, exd, wbwe, wba, $urandom);
            #1;
            e = model(pc, inst, fl, exwe, exmr, exd);
            checks++; if ({bus.hold_pc, bus.hold_if, bus.br, bus.except} !== {e.hold, e.hold, e.br, e.exc}) begin
                failures++; $display("FAIL rnd_comb n=%0d inst=%h got=%b exp=%b", n, inst, {bus.hold_pc, bus.hold_if, bus.br, bus.except}, {e.hold, e.hold, e.br, e.exc}); end
            if (e.br) begin
                checks++; if (bus.pc_branch !== e.target) begin failures++; $display("FAIL rnd_target n=%0d inst=%h got=%h exp=%h", n, inst, bus.pc_branch, e.target); end
            end
            @(posedge clk); #1;
            checks++; if (bus.id_valid !== e.valid || (!e.valid && bus.id_ctrl !== 6'd0)) begin
                failures++; $display("FAIL rnd_valid n=%0d inst=%h got v=%b ctrl=%b exp v=%b", n, inst, bus.id_valid, bus.id_ctrl, e.valid); end
            if (e.valid) begin
                checks++; if ({bus.id_pc, bus.id_rs_val, bus.id_rt_val, bus.id_imm} !== {e.pc, e.a, e.b, e.imm}) begin
                    failures++; $display("FAIL rnd_data n=%0d inst=%h got=%h exp=%h", n, inst, {bus.id_pc, bus.id_rs_val, bus.id_rt_val, bus.id_imm}, {e.pc, e.a, e.b, e.imm}); end
                checks++; if ({bus.id_rs, bus.id_rt, bus.id_rd, 4'(bus.id_alu_op), 6'(bus.id_ctrl)} !== {e.rs, e.rt, e.rd, 4'(e.alu), e.ctrl}) begin
                    failures++; $display("FAIL rnd_fields n=%0d inst=%h got=%h exp=%h", n, inst, {bus.id_rs, bus.id_rt, bus.id_rd, 4'(bus.id_alu_op), 6'(bus.id_ctrl)}, {e.rs, e.rt, e.rd, 4'(e.alu), e.ctrl}); end
            end
        end
    endtask

    initial begin
        bus.pc_in = '0; bus.inst_in = '0; bus.flush = 1'b0;
        bus.ex_reg_we = 1'b0; bus.ex_mem_read = 1'b0; bus.ex_dest = '0;
        bus.wb_we = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
        test_reset();
        test_addi();
        test_load_use();
        test_branch();
        test_jal();
        test_except_flush();
        test_wb_bypass();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
